// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and
// fixed constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one-outstanding-read fetcher feeding the decoder
// over valid/ready. Optional retired-instruction counter behind FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
`ifdef FETCH_PERF_EN
  output logic [31:0] retired_count,
`endif
  output logic        halted
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         handshake;

  assign handshake = (state_q == ST_HOLD) && instr_ready;

  // Priority below reset: halt, then redirect, then the normal fetch cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (halt) begin
      state_d = ST_HALTED;
    end else if ((state_q != ST_HALTED) && redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT: begin
          instr_d    = mem_rdata;
          instr_pc_d = pc_q;
          state_d    = ST_HOLD;
        end
        ST_HOLD: begin
          if (instr_ready) begin
            pc_d    = pc_q + INSTR_BYTES;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_HALTED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC & 32'hFFFF_FFFC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] retired_q, retired_d;

  // A handshake only exists in HOLD, so the count is naturally frozen in HALTED.
  always_comb begin
    retired_d = retired_q;
    if (handshake) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired_count = retired_q;
`endif

  assign mem_addr    = pc_q;
  assign mem_rstrb   = (state_q == ST_FETCH) && !reset;
  assign instr_valid = (state_q == ST_HOLD) && !reset;
  assign halted      = (state_q == ST_HALTED) && !reset;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  logic unused_handshake;
  assign unused_handshake = handshake;

endmodule
